// File: rtl/plot_pkg.sv
// Shared screen geometry, colour type and arbiter state encoding for the plot arbiter.
package plot_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef logic [2:0] colour_t;

  localparam colour_t CLEAR_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLOT,
    ST_GAP,
    ST_CLEAR
  } state_t;

  function automatic logic in_range(input logic [7:0] px, input logic [7:0] py,
                                    input int unsigned w, input int unsigned h);
    return (32'(px) < w) && (32'(py) < h);
  endfunction

endpackage

// File: rtl/plot_clear_scanner.sv
// Raster counter for the clear sweep: start returns to the origin, advance steps in x then y.
module plot_clear_scanner #(
  parameter int unsigned SCREEN_W = plot_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = plot_pkg::SCREEN_H
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       advance,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       last
);

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
  localparam logic [7:0] Y_MAX = 8'(SCREEN_H - 1);

  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_MAX) && (y_q == Y_MAX);

  // Holds at the final pixel so the counters never exceed the screen bounds.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start) begin
      x_d = '0;
      y_d = '0;
    end else if (advance && !last) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Two-player round-robin plot arbiter for a VGA adapter, with a full-screen clear sweep.
module plot_arbiter #(
  parameter int unsigned       SCREEN_W     = plot_pkg::SCREEN_W,
  parameter int unsigned       SCREEN_H     = plot_pkg::SCREEN_H,
  parameter plot_pkg::colour_t CLEAR_COLOUR = plot_pkg::CLEAR_COLOUR
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic [7:0] px0,
  input  logic [7:0] py0,
  input  logic [2:0] pc0,
  input  logic [7:0] px1,
  input  logic [7:0] py1,
  input  logic [2:0] pc1,
  output logic [1:0] ack,
  input  logic       clear_start,
  output logic       clear_busy,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       draw_en
);

  import plot_pkg::*;

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
  localparam logic [7:0] Y_MAX = 8'(SCREEN_H - 1);

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  colour_t    colour_q, colour_d;
  logic       draw_en_q, draw_en_d;
  logic [1:0] ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       pend_q, pend_d;
  logic       last_grant_q, last_grant_d;
  logic       grant;

  logic [7:0] scan_x, scan_y;
  logic       scan_last;
  logic       scan_start, scan_adv;

  // Scanner runs one pixel ahead of x_q/y_q so the registered outputs can load it directly.
  assign scan_start = (state_d != ST_CLEAR);
  assign scan_adv   = (state_d == ST_CLEAR);

  plot_clear_scanner #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_scanner (
    .clk    (clk),
    .resetn (resetn),
    .start  (scan_start),
    .advance(scan_adv),
    .x      (scan_x),
    .y      (scan_y),
    .last   (scan_last)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    draw_en_d    = 1'b0;
    ack_d        = '0;
    busy_d       = 1'b0;
    pend_d       = pend_q | clear_start;
    last_grant_d = last_grant_q;
    grant        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q || clear_start) begin
          state_d   = ST_CLEAR;
          pend_d    = 1'b0;
          busy_d    = 1'b1;
          draw_en_d = 1'b1;
          x_d       = '0;
          y_d       = '0;
          colour_d  = CLEAR_COLOUR;
        end else if (|req) begin
          grant        = (req == 2'b11) ? ~last_grant_q : req[1];
          state_d      = ST_PLOT;
          last_grant_d = grant;
          ack_d        = grant ? 2'b10 : 2'b01;
          x_d          = grant ? px1 : px0;
          y_d          = grant ? py1 : py0;
          colour_d     = grant ? pc1 : pc0;
          draw_en_d    = in_range(x_d, y_d, SCREEN_W, SCREEN_H);
        end
      end
      ST_PLOT: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      ST_CLEAR: begin
        if ((x_q == X_MAX) && (y_q == Y_MAX)) begin
          state_d = ST_GAP;
        end else begin
          busy_d    = 1'b1;
          draw_en_d = 1'b1;
          x_d       = scan_x;
          y_d       = scan_y;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      draw_en_q    <= 1'b0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
      pend_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      draw_en_q    <= draw_en_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign ack        = ack_q;
  assign clear_busy = busy_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign draw_en    = draw_en_q;

  logic unused_scan_last;
  assign unused_scan_last = scan_last;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter: plots, contention, range limits, clear and reset.
module tb_plot_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] req;
  logic [7:0] px0, py0, px1, py1;
  logic [2:0] pc0, pc1;
  logic [1:0] ack;
  logic       clear_start;
  logic       clear_busy;
  logic [7:0] x, y;
  logic [2:0] colour;
  logic       draw_en;

  int n_assert = 0;
  int n_fail   = 0;

  plot_arbiter #(
    .SCREEN_W    (160),
    .SCREEN_H    (120),
    .CLEAR_COLOUR(3'b000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .px0        (px0),
    .py0        (py0),
    .pc0        (pc0),
    .px1        (px1),
    .py1        (py1),
    .pc1        (pc1),
    .ack        (ack),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .draw_en    (draw_en)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks until clear_busy drops (bounded), counting cycles in which it stayed high.
  task automatic wait_busy_fall(output int n);
    n = 0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (!clear_busy) return;
      n++;
    end
    chk("busy_timeout", 32'(clear_busy), 32'd0);
  endtask

  initial begin
    int n, bad, ex, ey, lastx, lasty, extra;
    logic [1:0] exp_ack;

    resetn = 1'b0; req = '0; clear_start = 1'b0;
    px0 = '0; py0 = '0; pc0 = '0; px1 = '0; py1 = '0; pc1 = '0;
    tick(); tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_draw", 32'(draw_en), 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_colour", 32'(colour), 32'd0);
    resetn = 1'b1;
    tick();
    chk("idle_ack", 32'(ack), 32'd0);

    // Single in-range plot from player 0
    req = 2'b01; px0 = 8'd10; py0 = 8'd50; pc0 = 3'b100;
    tick();
    chk("single_ack", 32'(ack), 32'd1);
    chk("single_draw", 32'(draw_en), 32'd1);
    chk("single_x", 32'(x), 32'd10);
    chk("single_y", 32'(y), 32'd50);
    chk("single_colour", 32'(colour), 32'd4);
    req = 2'b00;
    tick();
    chk("single_gap_draw", 32'(draw_en), 32'd0);
    chk("single_gap_ack", 32'(ack), 32'd0);
    tick();

    // Out-of-range request from player 1: acked, never drawn
    req = 2'b10; px1 = 8'd200; py1 = 8'd5; pc1 = 3'b111;
    tick();
    chk("oor_ack", 32'(ack), 32'd2);
    chk("oor_draw", 32'(draw_en), 32'd0);
    req = 2'b00;
    tick();
    chk("oor_draw2", 32'(draw_en), 32'd0);
    chk("oor_ack2", 32'(ack), 32'd0);
    tick();
    chk("oor_draw3", 32'(draw_en), 32'd0);

    // Contention: both held, round-robin every 3 cycles starting with player 0
    px0 = 8'd1; py0 = 8'd2; pc0 = 3'd1; px1 = 8'd3; py1 = 8'd4; pc1 = 3'd2;
    req = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_ack = (k % 3 == 1) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("rr_ack_%0d", k), 32'(ack), 32'(exp_ack));
      chk($sformatf("rr_draw_%0d", k), 32'(draw_en), (k % 3 == 1) ? 32'd1 : 32'd0);
      if (k % 3 == 1) chk($sformatf("rr_x_%0d", k), 32'(x), (exp_ack == 2'b01) ? 32'd1 : 32'd3);
    end
    req = 2'b00;
    tick();

    // Boundary coordinates
    req = 2'b01; px0 = 8'd159; py0 = 8'd119; pc0 = 3'd5;
    tick();
    chk("edge_ack", 32'(ack), 32'd1);
    chk("edge_draw", 32'(draw_en), 32'd1);
    chk("edge_x", 32'(x), 32'd159);
    chk("edge_y", 32'(y), 32'd119);
    req = 2'b00; tick(); tick();
    req = 2'b01; px0 = 8'd160; py0 = 8'd0;
    tick();
    chk("xw_ack", 32'(ack), 32'd1);
    chk("xw_draw", 32'(draw_en), 32'd0);
    req = 2'b00; tick(); tick();
    req = 2'b01; px0 = 8'd0; py0 = 8'd120;
    tick();
    chk("yh_ack", 32'(ack), 32'd1);
    chk("yh_draw", 32'(draw_en), 32'd0);
    req = 2'b00; tick(); tick();

    // Request raised during PLOT/GAP and withdrawn before IDLE is never acked
    req = 2'b01; px0 = 8'd5; py0 = 8'd5;
    tick();
    chk("wd_first_ack", 32'(ack), 32'd1);
    req = 2'b10;
    tick();
    req = 2'b00;
    tick();
    tick();
    chk("wd_ack", 32'(ack), 32'd0);
    chk("wd_draw", 32'(draw_en), 32'd0);

    // Clear with player 0 held: clear wins, full sweep, then ack two cycles after busy falls
    req = 2'b01; px0 = 8'd3; py0 = 8'd4; pc0 = 3'd2; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("clr_busy0", 32'(clear_busy), 32'd1);
    chk("clr_draw0", 32'(draw_en), 32'd1);
    chk("clr_x0", 32'(x), 32'd0);
    chk("clr_y0", 32'(y), 32'd0);
    chk("clr_colour0", 32'(colour), 32'd0);
    chk("clr_ack0", 32'(ack), 32'd0);
    n = 1; ex = 0; ey = 0; bad = 0; lastx = 0; lasty = 0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (!clear_busy) break;
      if (ex == 159) begin ex = 0; ey++; end else ex++;
      if (32'(x) !== ex || 32'(y) !== ey || draw_en !== 1'b1 || ack !== 2'b00 || colour !== 3'b000)
        bad++;
      lastx = 32'(x); lasty = 32'(y);
      n++;
    end
    chk("clr_count", n, 32'd19200);
    chk("clr_pixel_errs", bad, 32'd0);
    chk("clr_last_x", lastx, 32'd159);
    chk("clr_last_y", lasty, 32'd119);
    chk("clr_gap_draw", 32'(draw_en), 32'd0);
    chk("clr_gap_ack", 32'(ack), 32'd0);
    tick();
    chk("clr_idle_ack", 32'(ack), 32'd0);
    tick();
    chk("clr_post_ack", 32'(ack), 32'd1);
    chk("clr_post_draw", 32'(draw_en), 32'd1);
    chk("clr_post_x", 32'(x), 32'd3);
    chk("clr_post_y", 32'(y), 32'd4);
    chk("clr_post_colour", 32'(colour), 32'd2);
    req = 2'b00;
    tick(); tick();

    // clear_start during a sweep queues a second full sweep
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("reclr_busy0", 32'(clear_busy), 32'd1);
    for (int i = 0; i < 100; i++) tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    wait_busy_fall(extra);
    chk("reclr_count", 1 + 101 + extra, 32'd19200);
    chk("reclr_gap_busy", 32'(clear_busy), 32'd0);
    tick();
    chk("reclr_idle_busy", 32'(clear_busy), 32'd0);
    tick();
    chk("reclr2_busy", 32'(clear_busy), 32'd1);
    chk("reclr2_draw", 32'(draw_en), 32'd1);
    chk("reclr2_x", 32'(x), 32'd0);
    chk("reclr2_y", 32'(y), 32'd0);

    // Reset at sweep pixel 500 aborts the clear
    for (int i = 0; i < 500; i++) tick();
    chk("p500_x", 32'(x), 32'd20);
    chk("p500_y", 32'(y), 32'd3);
    resetn = 1'b0;
    tick();
    chk("mrst_draw", 32'(draw_en), 32'd0);
    chk("mrst_busy", 32'(clear_busy), 32'd0);
    chk("mrst_x", 32'(x), 32'd0);
    chk("mrst_y", 32'(y), 32'd0);
    chk("mrst_ack", 32'(ack), 32'd0);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack !== 2'b00 || draw_en !== 1'b0 || clear_busy !== 1'b0) bad++;
    end
    chk("post_rst_quiet", bad, 32'd0);

    // Fresh request after reset is acked normally
    req = 2'b10; px1 = 8'd7; py1 = 8'd8; pc1 = 3'd1;
    tick();
    chk("fresh_ack", 32'(ack), 32'd2);
    chk("fresh_draw", 32'(draw_en), 32'd1);
    chk("fresh_x", 32'(x), 32'd7);
    req = 2'b00;
    tick();
    chk("fresh_ack_drop", 32'(ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter SCREEN_W, default 160, pixel columns; valid x is 0..SCREEN_W-1.
REQ-002 Parameter SCREEN_H, default 120, pixel rows; valid y is 0..SCREEN_H-1.
REQ-003 Parameter CLEAR_COLOUR, default 3'b000, colour written by the clear sweep.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 req  in  2  per-requester plot request; bit 0 = player 0, bit 1 = player 1.
REQ-007 px0, py0  in  8, 8  player 0 pixel coordinates; colour input pc0 is 3 bits wide.
REQ-008 px1, py1  in  8, 8  player 1 pixel coordinates; colour input pc1 is 3 bits wide.
REQ-009 ack  out  2  one-cycle acceptance pulse per requester.
REQ-010 clear_start  in  1  pulse; request a full-screen clear.
REQ-011 clear_busy  out  1  high while the clear sweep is running.
REQ-012 x, y  out  8, 8  pixel coordinates to the VGA adapter; colour is a 3-bit output.
REQ-013 draw_en  out  1  plot strobe to the VGA adapter.

Function
REQ-014 States SHALL be IDLE, PLOT, GAP and CLEAR; all outputs SHALL be registered.
REQ-015 Handshake: a requester SHALL hold req and its x/y/colour stable until it sees its ack bit high, then drop req or present new data.
REQ-016 In IDLE with clear_pending=0 and any req bit high, the arbiter SHALL grant one requester on the next edge: latch that requester's x/y/colour, pulse ack[g] for one cycle, set draw_en=1 and enter PLOT.
REQ-017 Tie-break SHALL be round-robin: when both req bits are high, grant the requester not granted last; last_grant resets to 1, so player 0 wins the first tie.
REQ-018 Timing: ack[g] and draw_en SHALL be high in the same cycle, one cycle after req was sampled in IDLE.
REQ-019 PLOT SHALL last exactly one cycle, then GAP with draw_en=0 for one cycle, then IDLE; sustained throughput is one plot per 3 cycles.
REQ-020 Out-of-range request (x>=SCREEN_W or y>=SCREEN_H): the request SHALL be acked but draw_en stays 0, and the state passes through PLOT/GAP as normal.
REQ-021 Any req bit that falls before its ack SHALL be treated as withdrawn, with no ack and no plot.
REQ-022 clear_start SHALL set clear_pending in any state; clear_pending is serviced at the next IDLE and takes priority over req.
REQ-023 CLEAR entry SHALL set clear_busy=1, x=0, y=0, colour=CLEAR_COLOUR and draw_en=1.
REQ-024 In CLEAR, draw_en SHALL stay high every cycle; x increments and wraps 159->0 with y+1.
REQ-025 The sweep SHALL end after pixel (159,119): 19200 draw_en cycles, then GAP with clear_busy=0, then IDLE.
REQ-026 A clear_start arriving during CLEAR SHALL set clear_pending again, and a second full sweep follows.
REQ-027 No ack SHALL be issued during CLEAR; pending reqs are served after it, round-robin state unchanged.
REQ-028 Coordinate arithmetic SHALL be 8-bit unsigned; the sweep counters never exceed SCREEN_W-1 / SCREEN_H-1.

Reset
REQ-029 With resetn=0 at an edge, the block SHALL set state=IDLE, x=0, y=0, colour=0, draw_en=0, ack=0, clear_busy=0, clear_pending=0, last_grant=1 and sweep counters=0.
REQ-030 Reset SHALL abort a PLOT or CLEAR in progress; the requester re-presents its req and is acked afresh, with no ack pulse left over from before reset.

Structure
REQ-031 Shared package plot_pkg SHALL hold SCREEN_W, SCREEN_H, CLEAR_COLOUR, the 3-bit colour type and the state enumeration.
REQ-032 The raster counter SHALL be the sub-module plot_clear_scanner.
REQ-033 plot_clear_scanner inputs: clk, resetn, start, advance; outputs: x, y, last.

Verification
REQ-034 Single plot: req=01, px0=10, py0=50, pc0=100 -> next cycle ack=01, draw_en=1, x=10, y=50, colour=100; following cycle draw_en=0.
REQ-035 Contention: req=11 held with both requesters re-presenting -> ack order 01,10,01,10 with acks 3 cycles apart; draw_en pulses never adjacent.
REQ-036 Out of range: req=10, px1=200, py1=5 -> ack=10, draw_en stays 0 for the whole transaction.
REQ-037 Clear: pulse clear_start with req=01 held -> exactly 19200 consecutive draw_en cycles, first (0,0), last (159,119), colour 000; ack=01 arrives 2 cycles after clear_busy falls.
REQ-038 Reset mid-clear: resetn=0 at sweep pixel 500 -> next cycle draw_en=0, clear_busy=0, x=0, y=0; no ack pulse after reset is released.
